// File: rtl/adder_accum.sv
// Packet accumulator: sums the tdata words of each AXI-Stream packet and holds the result until the host takes it.
// Optional build macro ADDER_SATURATE_EN clamps the sum to all-ones on carry instead of wrapping.
module adder_accum #(
  parameter int DATAW  = 128,
  parameter int COUNTW = 16,
  parameter int DESTW  = 4,
  parameter int IDW    = 32,
  parameter int USERW  = 66,
  parameter int KEEPW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axis_adder_interface_tvalid,
  output logic              axis_adder_interface_tready,
  input  logic              axis_adder_interface_tlast,
  input  logic [DATAW-1:0]  axis_adder_interface_tdata,
  input  logic [DESTW-1:0]  axis_adder_interface_tdest,
  input  logic [IDW-1:0]    axis_adder_interface_tid,
  input  logic [KEEPW-1:0]  axis_adder_interface_tstrb,
  input  logic [KEEPW-1:0]  axis_adder_interface_tkeep,
  input  logic [USERW-1:0]  axis_adder_interface_tuser,
  output logic              response_valid,
  input  logic              response_ready,
  output logic [DATAW-1:0]  response_sum,
  output logic [COUNTW-1:0] response_count,
  output logic              response_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATAW-1:0]    acc_r;
  logic [COUNTW-1:0]   cnt_r;
  logic                ovf_r;

  logic [DATAW:0]      sum_s;
  logic [DATAW-1:0]    sum_res_s;
  logic [COUNTW-1:0]   cnt_inc_s;
  logic                beat_s;
  logic                unused_s;

  assign unused_s = ^{axis_adder_interface_tdest, axis_adder_interface_tid,
                      axis_adder_interface_tstrb, axis_adder_interface_tkeep,
                      axis_adder_interface_tuser};

  // Ready depends on state alone so there is no path from tvalid.
  assign axis_adder_interface_tready = (state_r != DONE);
  assign beat_s = axis_adder_interface_tvalid && axis_adder_interface_tready;

  // Next accumulator value with carry, and saturating beat count.
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, axis_adder_interface_tdata};
`ifdef ADDER_SATURATE_EN
    if (sum_s[DATAW]) begin
      sum_res_s = {DATAW{1'b1}};
    end else begin
      sum_res_s = sum_s[DATAW-1:0];
    end
`else
    sum_res_s = sum_s[DATAW-1:0];
`endif
    if (cnt_r == {COUNTW{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(COUNTW-1){1'b0}}, 1'b1};
    end
  end

  // Packet FSM, accumulator and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      acc_r             <= {DATAW{1'b0}};
      cnt_r             <= {COUNTW{1'b0}};
      ovf_r             <= 1'b0;
      response_valid    <= 1'b0;
      response_sum      <= {DATAW{1'b0}};
      response_count    <= {COUNTW{1'b0}};
      response_overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (beat_s) begin
            if (axis_adder_interface_tlast) begin
              response_valid    <= 1'b1;
              response_sum      <= sum_res_s;
              response_count    <= cnt_inc_s;
              response_overflow <= ovf_r | sum_s[DATAW];
              acc_r             <= {DATAW{1'b0}};
              cnt_r             <= {COUNTW{1'b0}};
              ovf_r             <= 1'b0;
              state_r           <= DONE;
            end else begin
              acc_r   <= sum_res_s;
              cnt_r   <= cnt_inc_s;
              ovf_r   <= ovf_r | sum_s[DATAW];
              state_r <= ACCUM;
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          if (response_ready) begin
            response_valid <= 1'b0;
            state_r        <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r        <= IDLE;
          response_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accum.sv
// Self-checking bench for adder_accum: directed literal cases plus randomized traffic against a packet-level model.
module tb_adder_accum;
  localparam int DATAW  = 128;
  localparam int COUNTW = 4;
  localparam int DESTW  = 4;
  localparam int IDW    = 32;
  localparam int USERW  = 66;
  localparam int KEEPW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              tvalid, tlast;
  logic              tready;
  logic [DATAW-1:0]  tdata;
  logic [DESTW-1:0]  tdest;
  logic [IDW-1:0]    tid;
  logic [KEEPW-1:0]  tstrb, tkeep;
  logic [USERW-1:0]  tuser;
  logic              response_valid, response_ready, response_overflow;
  logic [DATAW-1:0]  response_sum;
  logic [COUNTW-1:0] response_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  localparam logic [DATAW-1:0] ONES = {DATAW{1'b1}};

  adder_accum #(.DATAW(DATAW), .COUNTW(COUNTW), .DESTW(DESTW), .IDW(IDW),
                .USERW(USERW), .KEEPW(KEEPW)) dut (
    .clk(clk), .rst(rst),
    .axis_adder_interface_tvalid(tvalid), .axis_adder_interface_tready(tready),
    .axis_adder_interface_tlast(tlast), .axis_adder_interface_tdata(tdata),
    .axis_adder_interface_tdest(tdest), .axis_adder_interface_tid(tid),
    .axis_adder_interface_tstrb(tstrb), .axis_adder_interface_tkeep(tkeep),
    .axis_adder_interface_tuser(tuser),
    .response_valid(response_valid), .response_ready(response_ready),
    .response_sum(response_sum), .response_count(response_count),
    .response_overflow(response_overflow)
  );

  always #5 clk = ~clk;

  // Packet-level model: exact wide total of the packet, then the output rules applied once.
  logic                 m_pend = 1'b0;
  logic [DATAW-1:0]     m_sum  = '0;
  logic [COUNTW-1:0]    m_cnt  = '0;
  logic                 m_ovf  = 1'b0;
  logic [DATAW+31:0]    m_total = '0;
  int                   m_n = 0;

  function automatic logic [DATAW-1:0] exp_sum(input logic [DATAW+31:0] t);
    logic big;
    big = (t >= ({{31{1'b0}}, 1'b1, {DATAW{1'b0}}}));
`ifdef ADDER_SATURATE_EN
    return big ? ONES : t[DATAW-1:0];
`else
    return t[DATAW-1:0];
`endif
  endfunction

  function automatic logic [COUNTW-1:0] exp_cnt(input int n);
    int mx;
    mx = (1 << COUNTW) - 1;
    return (n > mx) ? mx[COUNTW-1:0] : n[COUNTW-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0; m_sum <= '0; m_cnt <= '0; m_ovf <= 1'b0;
      m_total <= '0; m_n <= 0;
    end else if (m_pend) begin
      if (response_ready) m_pend <= 1'b0;
    end else if (tvalid) begin
      if (tlast) begin
        m_pend  <= 1'b1;
        m_sum   <= exp_sum(m_total + {32'd0, tdata});
        m_cnt   <= exp_cnt(m_n + 1);
        m_ovf   <= ((m_total + {32'd0, tdata}) >> DATAW) != 0;
        m_total <= '0;
        m_n     <= 0;
      end else begin
        m_total <= m_total + {32'd0, tdata};
        m_n     <= m_n + 1;
      end
    end
  end

  task automatic check(input string name, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous compare of the DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tready", {127'd0, tready}, {127'd0, !m_pend});
      check("model_valid", {127'd0, response_valid}, {127'd0, m_pend});
      if (m_pend) begin
        check("model_sum", response_sum, m_sum);
        check("model_count", {{(DATAW-COUNTW){1'b0}}, response_count}, {{(DATAW-COUNTW){1'b0}}, m_cnt});
        check("model_ovf", {127'd0, response_overflow}, {127'd0, m_ovf});
      end
    end
  end

  task automatic beat(input logic [DATAW-1:0] d, input logic last);
    tvalid = 1'b1; tdata = d; tlast = last;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic take();
    response_ready = 1'b1;
    @(posedge clk); #1;
    response_ready = 1'b0;
  endtask

  task automatic check_resp(input string name, input logic [DATAW-1:0] s, input int c, input logic o);
    check({name, "_valid"}, {127'd0, response_valid}, {{(DATAW-1){1'b0}}, 1'b1});
    check({name, "_sum"}, response_sum, s);
    check({name, "_count"}, {{(DATAW-COUNTW){1'b0}}, response_count}, c);
    check({name, "_ovf"}, {127'd0, response_overflow}, {127'd0, o});
    check({name, "_tready"}, {127'd0, tready}, '0);
  endtask

  function automatic logic [DATAW-1:0] rnd_data();
    logic [DATAW-1:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: return DATAW'($urandom_range(0, 15));
      1: return ONES - DATAW'($urandom_range(0, 15));
      2: return r;
      default: return {1'b1, r[DATAW-2:0]};
    endcase
  endfunction

  initial begin
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    tdest = '0; tid = '0; tstrb = '0; tkeep = '0; tuser = '0;
    response_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_valid", {127'd0, response_valid}, '0);
    check("rst_sum", response_sum, '0);
    check("rst_count", {{(DATAW-COUNTW){1'b0}}, response_count}, '0);
    check("rst_ovf", {127'd0, response_overflow}, '0);
    check("rst_tready", {127'd0, tready}, {{(DATAW-1){1'b0}}, 1'b1});

    // Single beat, then backpressure for 10 cycles
    beat(128'd5, 1'b1);
    check_resp("single", 128'd5, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_resp("hold", 128'd5, 1, 1'b0);
    end
    take();
    check("after_take_valid", {127'd0, response_valid}, '0);
    check("after_take_tready", {127'd0, tready}, {{(DATAW-1){1'b0}}, 1'b1});

    // Three-beat packet
    for (int i = 1; i <= 3; i++) begin
      check("three_tready", {127'd0, tready}, {{(DATAW-1){1'b0}}, 1'b1});
      beat(DATAW'(i), (i == 3));
    end
    check_resp("three", 128'd6, 3, 1'b0);
    take();

    // Overflow then a clean packet
    beat(ONES, 1'b0);
    beat(128'd2, 1'b1);
`ifdef ADDER_SATURATE_EN
    check_resp("ovf", ONES, 2, 1'b1);
`else
    check_resp("ovf", 128'd1, 2, 1'b1);
`endif
    take();
    beat(128'd4, 1'b1);
    check_resp("post_ovf", 128'd4, 1, 1'b0);
    take();

    // Reset mid-packet
    beat(128'd7, 1'b0);
    beat(128'd8, 1'b0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("midrst_tready", {127'd0, tready}, {{(DATAW-1){1'b0}}, 1'b1});
    beat(128'd1, 1'b0);
    beat(128'd1, 1'b1);
    check_resp("midrst", 128'd2, 2, 1'b0);
    take();

    // Reset while holding a result
    beat(128'd9, 1'b1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("donerst_valid", {127'd0, response_valid}, '0);

    // Back-to-back with response_ready high
    response_ready = 1'b1;
    beat(128'd10, 1'b0);
    beat(128'd20, 1'b1);
    check_resp("b2b_a", 128'd30, 2, 1'b0);
    tvalid = 1'b1; tdata = 128'd3; tlast = 1'b1;
    @(posedge clk); #1;
    check("b2b_gap_tready", {127'd0, tready}, {{(DATAW-1){1'b0}}, 1'b1});
    check("b2b_gap_valid", {127'd0, response_valid}, '0);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    check_resp("b2b_b", 128'd3, 1, 1'b0);
    @(posedge clk); #1;
    response_ready = 1'b0;

    // Beat count saturation (17 beats, 4-bit counter)
    for (int i = 1; i <= 17; i++) beat(128'd1, (i == 17));
    check_resp("cnt_sat", 128'd17, 15, 1'b0);
    take();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tvalid = ($urandom_range(0, 9) < 7);
      tdata  = rnd_data();
      tlast  = (c < 2000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 24) == 0);
      tdest  = DESTW'($urandom()); tid = $urandom();
      tstrb  = KEEPW'($urandom()); tkeep = KEEPW'($urandom());
      tuser  = {$urandom(), $urandom(), $urandom()};
      response_ready = $urandom_range(0, 1);
      rst    = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; tvalid = 1'b0; response_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
